// File: rtl/bram_arbiter_if.sv
// Bundle of requester, BRAM and status signals around the two-port BRAM arbiter.
// slave = arbiter side, master = client/BRAM side.
interface bram_arbiter_if #(
  parameter int ADDR_SZ = 8,
  parameter int DATA_SZ = 16
);
  logic               r0_req;
  logic               r0_wr;
  logic [ADDR_SZ-1:0] r0_addr;
  logic [DATA_SZ-1:0] r0_wdata;
  logic               r0_ack;
  logic [DATA_SZ-1:0] r0_rdata;

  logic               r1_req;
  logic               r1_wr;
  logic [ADDR_SZ-1:0] r1_addr;
  logic [DATA_SZ-1:0] r1_wdata;
  logic               r1_ack;
  logic [DATA_SZ-1:0] r1_rdata;

  logic               bram_wr_en;
  logic [ADDR_SZ-1:0] bram_waddr;
  logic [DATA_SZ-1:0] bram_wdata;
  logic               bram_rd_en;
  logic [ADDR_SZ-1:0] bram_raddr;
  logic [DATA_SZ-1:0] bram_rdata;
  logic               busy;

  modport slave (
    input  r0_req, r0_wr, r0_addr, r0_wdata,
    input  r1_req, r1_wr, r1_addr, r1_wdata,
    input  bram_rdata,
    output r0_ack, r0_rdata, r1_ack, r1_rdata,
    output bram_wr_en, bram_waddr, bram_wdata, bram_rd_en, bram_raddr,
    output busy
  );

  modport master (
    output r0_req, r0_wr, r0_addr, r0_wdata,
    output r1_req, r1_wr, r1_addr, r1_wdata,
    output bram_rdata,
    input  r0_ack, r0_rdata, r1_ack, r1_rdata,
    input  bram_wr_en, bram_waddr, bram_wdata, bram_rd_en, bram_raddr,
    input  busy
  );
endinterface

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-read BRAM between two requesters.
// Each access takes IDLE -> BUSY (strobe) -> DONE (ack), i.e. one access per 3 cycles.
module bram_arbiter #(
  parameter int ADDR_SZ = 8,
  parameter int DATA_SZ = 16
) (
  input  logic         clk,
  input  logic         rst,
  bram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_reg, state_next;
  logic               owner_reg, owner_next;
  logic               last_owner_reg, last_owner_next;
  logic               wr_en_reg, wr_en_next;
  logic               rd_en_reg, rd_en_next;
  logic [ADDR_SZ-1:0] waddr_reg, waddr_next;
  logic [DATA_SZ-1:0] wdata_reg, wdata_next;
  logic [ADDR_SZ-1:0] raddr_reg, raddr_next;
  logic               ack0_reg, ack0_next;
  logic               ack1_reg, ack1_next;
  logic               busy_reg, busy_next;

  logic               winner;
  logic               win_wr;
  logic [ADDR_SZ-1:0] win_addr;
  logic [DATA_SZ-1:0] win_wdata;

  // On a tie the side that did not own the previous access wins.
  assign winner    = (bus.r0_req && bus.r1_req) ? ~last_owner_reg : bus.r1_req;
  assign win_wr    = winner ? bus.r1_wr    : bus.r0_wr;
  assign win_addr  = winner ? bus.r1_addr  : bus.r0_addr;
  assign win_wdata = winner ? bus.r1_wdata : bus.r0_wdata;

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    wr_en_next      = 1'b0;
    rd_en_next      = 1'b0;
    waddr_next      = waddr_reg;
    wdata_next      = wdata_reg;
    raddr_next      = raddr_reg;
    ack0_next       = 1'b0;
    ack1_next       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.r0_req || bus.r1_req) begin
          owner_next      = winner;
          last_owner_next = winner;
          state_next      = BUSY;
          if (win_wr) begin
            wr_en_next = 1'b1;
            waddr_next = win_addr;
            wdata_next = win_wdata;
          end else begin
            rd_en_next = 1'b1;
            raddr_next = win_addr;
          end
        end
      end
      BUSY: begin
        state_next = DONE;
        ack0_next  = ~owner_reg;
        ack1_next  = owner_reg;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b1;
      wr_en_reg      <= 1'b0;
      rd_en_reg      <= 1'b0;
      waddr_reg      <= '0;
      wdata_reg      <= '0;
      raddr_reg      <= '0;
      ack0_reg       <= 1'b0;
      ack1_reg       <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      wr_en_reg      <= wr_en_next;
      rd_en_reg      <= rd_en_next;
      waddr_reg      <= waddr_next;
      wdata_reg      <= wdata_next;
      raddr_reg      <= raddr_next;
      ack0_reg       <= ack0_next;
      ack1_reg       <= ack1_next;
      busy_reg       <= busy_next;
    end
  end

  assign bus.bram_wr_en = wr_en_reg;
  assign bus.bram_waddr = waddr_reg;
  assign bus.bram_wdata = wdata_reg;
  assign bus.bram_rd_en = rd_en_reg;
  assign bus.bram_raddr = raddr_reg;
  assign bus.r0_ack     = ack0_reg;
  assign bus.r1_ack     = ack1_reg;
  assign bus.busy       = busy_reg;
  // Read data is the BRAM output steered to the acked side only.
  assign bus.r0_rdata   = ack0_reg ? bus.bram_rdata : '0;
  assign bus.r1_rdata   = ack1_reg ? bus.bram_rdata : '0;
endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural 1-cycle-latency BRAM.
module tb_bram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  bram_arbiter_if #(.ADDR_SZ(8), .DATA_SZ(16)) bus ();
  bram_arbiter #(.ADDR_SZ(8), .DATA_SZ(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.bram_wr_en) mem[bus.bram_waddr] <= bus.bram_wdata;
    if (bus.bram_rd_en) bus.bram_rdata <= mem[bus.bram_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (!(bus.r0_ack || bus.r1_ack) && n < 6) begin
      tick();
      n++;
    end
  endtask

  int n, last_cyc;

  initial begin
    bus.r0_req = 0; bus.r0_wr = 0; bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_req = 0; bus.r1_wr = 0; bus.r1_addr = '0; bus.r1_wdata = '0;
    bus.bram_rdata = '0;

    // 1. reset state
    tick(); tick(); tick();
    chk("rst_wr_en", bus.bram_wr_en, 0);
    chk("rst_rd_en", bus.bram_rd_en, 0);
    chk("rst_acks", {bus.r0_ack, bus.r1_ack}, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_addr", {bus.bram_waddr, bus.bram_raddr, bus.bram_wdata}, 0);
    rst = 0;
    tick(); tick();
    chk("idle_busy", bus.busy, 0);
    chk("idle_strobes", {bus.bram_wr_en, bus.bram_rd_en}, 0);

    // 2. r0 write then read back
    bus.r0_req = 1; bus.r0_wr = 1; bus.r0_addr = 8'h05; bus.r0_wdata = 16'h1234;
    tick();
    chk("wr_strobe", {bus.bram_wr_en, bus.bram_rd_en}, 2'b10);
    chk("wr_waddr", bus.bram_waddr, 8'h05);
    chk("wr_wdata", bus.bram_wdata, 16'h1234);
    chk("wr_busy", bus.busy, 1);
    chk("wr_noack_T1", bus.r0_ack, 0);
    bus.r0_wr = 0; bus.r0_wdata = 16'hFFFF; // post-grant changes must not matter
    tick();
    chk("wr_ack", {bus.r0_ack, bus.r1_ack}, 2'b10);
    chk("wr_strobe_off", bus.bram_wr_en, 0);
    bus.r0_req = 0;
    tick();
    chk("wr_ack_once", bus.r0_ack, 0);
    chk("wr_idle", bus.busy, 0);
    $display("txn r0 write 05=1234 done");
    bus.r0_req = 1; bus.r0_wr = 0; bus.r0_addr = 8'h05;
    tick();
    chk("rd_strobe", {bus.bram_wr_en, bus.bram_rd_en}, 2'b01);
    chk("rd_raddr", bus.bram_raddr, 8'h05);
    tick();
    chk("rd_ack", bus.r0_ack, 1);
    chk("rd_data", bus.r0_rdata, 16'h1234);
    $display("txn r0 read 05 -> %0h", bus.r0_rdata);
    bus.r0_req = 0;
    tick();

    // 3. tie just after reset: r0 wins, r1 follows
    rst = 1; tick(); rst = 0;
    bus.r0_req = 1; bus.r0_wr = 0; bus.r0_addr = 8'h05;
    bus.r1_req = 1; bus.r1_wr = 0; bus.r1_addr = 8'h05;
    tick();
    chk("tie_T1_acks", {bus.r0_ack, bus.r1_ack}, 0);
    tick();
    chk("tie_T2_acks", {bus.r0_ack, bus.r1_ack}, 2'b10);
    chk("tie_r0_data", bus.r0_rdata, 16'h1234);
    $display("txn r0 read (tie) -> %0h", bus.r0_rdata);
    bus.r0_req = 0;
    tick();
    chk("tie_T3_acks", {bus.r0_ack, bus.r1_ack}, 0);
    tick();
    chk("tie_T4_rd", bus.bram_rd_en, 1);
    chk("tie_T4_acks", {bus.r0_ack, bus.r1_ack}, 0);
    tick();
    chk("tie_T5_acks", {bus.r0_ack, bus.r1_ack}, 2'b01);
    chk("tie_r1_data", bus.r1_rdata, 16'h1234);
    $display("txn r1 read (tie) -> %0h", bus.r1_rdata);
    bus.r1_req = 0;
    tick();

    // 4. both held: alternate 0,1,0,1,0,1 three cycles apart
    bus.r0_req = 1; bus.r1_req = 1;
    last_cyc = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      wait_ack(n);
      chk("rr_timeout", (n < 6), 1);
      chk("rr_one_ack", bus.r0_ack & bus.r1_ack, 0);
      chk("rr_owner", bus.r1_ack, k % 2);
      if (k > 0) chk("rr_gap", cyc - last_cyc, 3);
      last_cyc = cyc;
      $display("txn rr %0d owner r%0d at cycle %0d", k, bus.r1_ack, cyc);
    end
    bus.r0_req = 0; bus.r1_req = 0;
    tick(); tick();

    // 5. make r0 last owner, then r1 write wins contention over r0 read
    bus.r0_req = 1; bus.r0_wr = 0; bus.r0_addr = 8'h05;
    tick(); tick();
    chk("pre_ack", bus.r0_ack, 1);
    bus.r0_req = 0;
    tick();
    bus.r1_req = 1; bus.r1_wr = 1; bus.r1_addr = 8'h7F; bus.r1_wdata = 16'hBEEF;
    bus.r0_req = 1; bus.r0_wr = 0; bus.r0_addr = 8'h7F;
    tick();
    chk("c_wr_en", bus.bram_wr_en, 1);
    chk("c_waddr", bus.bram_waddr, 8'h7F);
    chk("c_wdata", bus.bram_wdata, 16'hBEEF);
    tick();
    chk("c_r1_ack", {bus.r0_ack, bus.r1_ack}, 2'b01);
    $display("txn r1 write 7F=BEEF done");
    bus.r1_req = 0;
    tick(); tick();
    chk("c_rd_en", bus.bram_rd_en, 1);
    chk("c_raddr", bus.bram_raddr, 8'h7F);
    tick();
    chk("c_r0_ack", {bus.r0_ack, bus.r1_ack}, 2'b10);
    chk("c_r0_data", bus.r0_rdata, 16'hBEEF);
    $display("txn r0 read 7F -> %0h", bus.r0_rdata);
    bus.r0_req = 0;
    tick();

    // 6. reset during BUSY of r0 read; r0 keeps req and is served after release
    bus.r0_req = 1; bus.r0_wr = 0; bus.r0_addr = 8'h7F;
    tick();
    chk("m_busy_rd", bus.bram_rd_en, 1);
    rst = 1;
    tick();
    chk("m_no_ack", {bus.r0_ack, bus.r1_ack}, 0);
    chk("m_idle", bus.busy, 0);
    chk("m_strobes", {bus.bram_wr_en, bus.bram_rd_en}, 0);
    chk("m_raddr", bus.bram_raddr, 0);
    rst = 0;
    wait_ack(n);
    chk("m_latency", n, 2);
    chk("m_ack", bus.r0_ack, 1);
    chk("m_data", bus.r0_rdata, 16'hBEEF);
    $display("txn r0 read after reset -> %0h", bus.r0_rdata);
    bus.r0_req = 0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
